// File: rtl/home_pkg.sv
// -----------------------------------------------------------------------------
// home_pkg
// Shared definitions for the sensor scan/debounce block:
//   - scan FSM state encoding (2 bits)
//   - fixed channel count and select width of the 4-to-1 sensor mux
//   - default timing/debounce parameters and the counter-width legality check
// -----------------------------------------------------------------------------
package home_pkg;

    // Channel count is tied to the physical mux input width.
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // Default timing / debounce parameters.
    localparam int unsigned DEF_SETTLE_CYC = 4;
    localparam int unsigned DEF_DEB_CNT    = 8;
    localparam int unsigned DEF_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_ADVANCE = 2'd3
    } scan_state_e;

    // A debounce counter must be able to hold the value DEB_CNT.
    function automatic bit cnt_w_ok(input int unsigned cnt_w, input int unsigned deb_cnt);
        return (cnt_w >= $clog2(deb_cnt + 32'd1));
    endfunction

    localparam bit CNT_W_OK = cnt_w_ok(DEF_CNT_W, DEF_DEB_CNT);

endpackage

// File: rtl/sensor_debounce_ch.sv
// -----------------------------------------------------------------------------
// sensor_debounce_ch
// Per-channel debounce counter. Counts consecutive samples that disagree with
// the current published status bit; after DEB_CNT of them it raises a flip
// strobe for that sample cycle and restarts. Any agreeing sample restarts the
// count. The flip strobe is only consumed by registered logic in the parent.
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_en_i  this channel is being sampled this cycle
//   sample_i     sampled sensor bit
//   status_i     current debounced status bit of this channel
//   flip_o       strobe: status bit must toggle at the end of this cycle
// -----------------------------------------------------------------------------
module sensor_debounce_ch #(
    parameter int unsigned DEB_CNT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic sample_i,
    input  logic status_i,
    output logic flip_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ_s;

    // Next-count and flip strobe; the count never passes DEB_CNT-1 because
    // reaching DEB_CNT flips the status and clears the count in one step.
    always_comb begin
        differ_s = sample_i ^ status_i;
        cnt_d    = cnt_q;
        flip_o   = 1'b0;
        if (sample_en_i) begin
            if (differ_s) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    flip_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sensor_scan_debounce.sv
// -----------------------------------------------------------------------------
// sensor_scan_debounce
// Scans a 4-to-1 sensor mux: drives sel, waits SETTLE_CYC cycles, samples
// mux_out once, then advances to the next channel. Each channel is debounced
// independently; a status bit flips after DEB_CNT consecutive disagreeing
// samples. At the end of every full scan a one-cycle scan_done is emitted,
// together with change_pulse and the mask of flipped channels when any
// channel flipped during that scan. All outputs are registered.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   en            scan enable (a channel in progress always completes)
//   mux_out       selected sensor bit from the mux
//   sel           channel select driven to the mux
//   status        debounced per-channel sensor state
//   scan_done     one-cycle pulse after the last channel is processed
//   change_pulse  one-cycle pulse with scan_done when any status bit flipped
//   changed_ch    mask of channels flipped in the last completed scan
// -----------------------------------------------------------------------------
module sensor_scan_debounce
    import home_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned DEB_CNT    = DEF_DEB_CNT,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] status,
    output logic              scan_done,
    output logic              change_pulse,
    output logic [NUM_CH-1:0] changed_ch
);

    localparam int unsigned       STL_W    = $clog2(SETTLE_CYC + 32'd1);
    localparam logic [STL_W-1:0]  STL_LAST = STL_W'(SETTLE_CYC - 32'd1);
    localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_CH - 32'd1);

    if (!CNT_W_OK || !cnt_w_ok(CNT_W, DEB_CNT) || (SETTLE_CYC < 32'd1) || (DEB_CNT < 32'd1))
    begin : g_param_err
        $error("sensor_scan_debounce: illegal SETTLE_CYC/DEB_CNT/CNT_W combination");
    end

    scan_state_e       state_q;
    logic [STL_W-1:0]  settle_cnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic [NUM_CH-1:0] status_q;
    logic [NUM_CH-1:0] scan_mask_q;
    logic [NUM_CH-1:0] changed_ch_q;
    logic              scan_done_q;
    logic              change_pulse_q;

    logic [NUM_CH-1:0] sample_en_s;
    logic [NUM_CH-1:0] flip_s;

    // One debounce counter per channel; only the selected channel is
    // enabled, and only in the SAMPLE cycle.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign sample_en_s[ch] = (state_q == ST_SAMPLE) && (sel_q == SEL_W'(ch));

        sensor_debounce_ch #(
            .DEB_CNT (DEB_CNT),
            .CNT_W   (CNT_W)
        ) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .sample_en_i (sample_en_s[ch]),
            .sample_i    (mux_out),
            .status_i    (status_q[ch]),
            .flip_o      (flip_s[ch])
        );
    end

    // Scan FSM with settle counter, select, status, scan mask and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            settle_cnt_q   <= '0;
            sel_q          <= '0;
            status_q       <= '0;
            scan_mask_q    <= '0;
            changed_ch_q   <= '0;
            scan_done_q    <= 1'b0;
            change_pulse_q <= 1'b0;
        end else begin
            scan_done_q    <= 1'b0;
            change_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == STL_LAST) begin
                        state_q      <= ST_SAMPLE;
                        settle_cnt_q <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + STL_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    // flip_s has at most the selected channel's bit set.
                    status_q    <= status_q ^ flip_s;
                    scan_mask_q <= scan_mask_q | flip_s;
                    state_q     <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (sel_q == SEL_LAST) begin
                        sel_q          <= '0;
                        scan_done_q    <= 1'b1;
                        change_pulse_q <= |scan_mask_q;
                        changed_ch_q   <= scan_mask_q;
                        scan_mask_q    <= '0;
                    end else begin
                        sel_q <= sel_q + SEL_W'(1);
                    end
                    settle_cnt_q <= '0;
                    state_q      <= en ? ST_SETTLE : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel          = sel_q;
    assign status       = status_q;
    assign scan_done    = scan_done_q;
    assign change_pulse = change_pulse_q;
    assign changed_ch   = changed_ch_q;

endmodule

// File: doc/sensor_scan_debounce.md
Name: sensor_scan_debounce

Overview:
- Upstream control stage for the 4-input sensor mux.
- Drives the mux select and waits for the mux output to settle. It then samples the mux output and debounces each of the 4 channels independently.
- Publishes a stable per-channel status vector plus a once-per-scan change event to the home-automation control logic.

Parameters:
- NUM_CH, 4, channels scanned; fixed to the mux input width.
- SEL_W, 2, select width; equals log2(NUM_CH).
- SETTLE_CYC, 4, cycles sel is held before sampling; must be >=1.
- DEB_CNT, 8, consecutive differing samples needed to flip a status bit; must be >=1.
- CNT_W, 4, debounce counter width; must be >= clog2(DEB_CNT+1).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, scan enable.
- mux_out, input, 1, selected sensor bit returned from the 4-to-1 mux.
- sel, output, SEL_W, channel select driven to the mux.
- status, output, NUM_CH, debounced sensor state, one bit per channel.
- scan_done, output, 1, one-cycle pulse after channel NUM_CH-1 is processed.
- change_pulse, output, 1, one-cycle pulse, coincident with scan_done, only when at least one status bit flipped during that scan.
- changed_ch, output, NUM_CH, mask of channels that flipped during the last completed scan.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, any cycle, any state):
  - FSM goes to IDLE.
  - sel=0, status=0, changed_ch=0, scan_done=0, change_pulse=0.
  - All debounce counters, the settle counter and the scan mask are cleared.
- FSM states: IDLE, SETTLE, SAMPLE, ADVANCE.
- IDLE: sel held. If en=1, go to SETTLE with the settle counter cleared.
- SETTLE: sel held for exactly SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle): mux_out is captured for channel c=sel.
  - If mux_out != status[c], counter[c] increments.
  - When the increment reaches DEB_CNT, status[c] toggles, counter[c] clears and scan mask bit c sets. The new status is visible in the ADVANCE cycle.
  - If mux_out == status[c], counter[c] clears. A single agreeing sample fully restarts debounce.
- ADVANCE (1 cycle):
  - sel <= sel+1, wrapping from NUM_CH-1 to 0.
  - If sel was NUM_CH-1, on the next cycle: scan_done=1 for one cycle; changed_ch <= scan mask; change_pulse = |scan mask; scan mask cleared.
  - changed_ch holds until the next scan_done.
  - If en=1, go to SETTLE; otherwise go to IDLE.
- Timing (defaults):
  - Per-channel cost is SETTLE_CYC+2 = 6 cycles; a full scan is 24 cycles.
  - From the first IDLE->SETTLE transition, scan_done first rises in cycle 25.
  - A step input flips status after exactly DEB_CNT consecutive scans.
- en deasserted mid-channel: the current channel completes through ADVANCE, then the FSM idles. sel, counters, status and the partial scan mask are retained. On re-enable the scan resumes at the retained sel.
- Simultaneous flips in one scan are reported by a single change_pulse with a multi-bit mask.
- DEB_CNT=1: status follows each sample immediately.
- Counters never exceed DEB_CNT, so no saturation logic is needed.
- mux_out is not sampled outside SAMPLE.
- No combinational path from mux_out to any output.

Decomposition:
- Shared package (home_pkg):
  - State enum (IDLE/SETTLE/SAMPLE/ADVANCE), 2 bits.
  - NUM_CH and SEL_W constants.
  - A localparam check for the CNT_W rule.
- One natural sub-module: sensor_debounce_ch, instantiated NUM_CH times.
  - Inputs: clk, rst_n, sample_en, sample, current status bit.
  - Outputs: flip strobe.
  - Owns its CNT_W counter.
- Top level keeps the FSM, settle counter, sel, status, scan mask and pulse outputs.

Test Plan:
1. Hold rst_n=0, then release with en=1 and all inputs 0 -> sel=0 in cycles 1-6, then 1, 2, 3; scan_done pulses in cycle 25 and every 24 cycles after; change_pulse stays 0; status=4'b0000.
2. Drive ch2 constant 1 from scan 1 -> status[2] rises during scan 8; change_pulse=1 and changed_ch=4'b0100 at scan 8's scan_done; no pulse in scans 1-7 or scan 9.
3. ch1 high for 7 scans, low for 1 scan, then high -> status[1] stays 0 until 8 further consecutive high scans; then changed_ch=4'b0010.
4. ch0 and ch3 rise in the same scan -> after 8 scans, one change_pulse with changed_ch=4'b1001; then drop both -> 8 scans later changed_ch=4'b1001 and status=4'b0000.
5. Deassert en while sel=1 in SETTLE -> ch1 is sampled, sel becomes 2, FSM idles with sel stable and no scan_done; re-assert en -> scanning resumes at sel=2 and scan_done arrives after ch3.
6. Pull rst_n low during SAMPLE with status=4'b0101 -> status, sel, changed_ch and counters read 0 in the same cycle without a clock edge; on release, debounce restarts from zero.
